piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter that accepts a WIDTH-bit parallel word through a load/ready handshake and shifts it out one bit per clock with a valid and a last-bit marker. It is the serializing end of the team's register datapath: it takes words from the parallel (PIPO-style) register stage and drives a single-wire serial link. Back-to-back words stream with no idle bubble.

---
 rtl/piso_serializer.sv | 113 +++++++++++
 tb/tb_piso_serializer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word
//               through a load/ready handshake and shifts it out one bit per
//               clock, with a valid flag and a last-bit marker. With load held
//               high, words stream back-to-back with no idle cycle between
//               them.
// Ports       : clk      - rising-edge clock
//               clear    - synchronous active-high reset
//               pi       - parallel word, sampled only on an accepting edge
//               load     - transfer request, accepted when load & ready
//               ready    - word can be accepted at this edge
//               so       - serial data bit (0 when so_valid = 0)
//               so_valid - so carries a valid bit this cycle
//               so_last  - current bit is the final bit of the word
//               busy     - frame in progress (equals so_valid)
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] pi,
    input  logic             load,
    output logic             ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0]    c_IDLE     = 1'b0;
    localparam logic [0:0]    c_SHIFT    = 1'b1;
    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_sreg_shifted;
    logic             w_out_bit;
    logic             w_shifting;
    logic             w_at_last;

    // Output end of the shift register and the one-bit advance toward it.
    // Vacated positions fill with zero.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
            assign w_out_bit      = r_sreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
            assign w_out_bit      = r_sreg[0];
        end
    endgenerate

    assign w_shifting = (r_state == c_SHIFT);
    assign w_at_last  = (r_cnt == c_CNT_LAST);

    // ready comes from registered state only, so the next word can be taken
    // on the same edge that retires the last bit of the current one.
    assign ready    = !w_shifting || w_at_last;
    assign so_valid = w_shifting;
    assign busy     = w_shifting;
    assign so       = w_shifting && w_out_bit;
    assign so_last  = w_shifting && w_at_last;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= c_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (load) begin
                        r_sreg  <= pi;
                        r_cnt   <= '0;
                        r_state <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    if (!w_at_last) begin
                        // Mid-word: load is ignored and pi is not sampled.
                        r_sreg <= w_sreg_shifted;
                        r_cnt  <= r_cnt + c_CNT_ONE;
                    end else if (load) begin
                        // Gapless hand-off to the next word.
                        r_sreg <= pi;
                        r_cnt  <= '0;
                    end else begin
                        r_state <= c_IDLE;
                        r_sreg  <= '0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_sreg  <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench for piso_serializer. Two instances with
//               WIDTH = 4 (MSB-first and LSB-first). Stimulus pushes expected
//               serial bits into per-instance queues; a negedge monitor pops
//               and compares whenever so_valid is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    typedef struct packed {
        logic b;
        logic last;
        logic contig;   // previous cycle must also have carried a valid bit
    } exp_t;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] pi0, pi1;
    logic       load0, load1;
    logic       ready0, so0, so_valid0, so_last0, busy0;
    logic       ready1, so1, so_valid1, so_last1, busy1;

    exp_t q0[$];
    exp_t q1[$];
    bit [1:0] prevv;
    bit       mon_en;

    int n_cmp;
    int n_err;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk      (clk),
        .clear    (clear),
        .pi       (pi0),
        .load     (load0),
        .ready    (ready0),
        .so       (so0),
        .so_valid (so_valid0),
        .so_last  (so_last0),
        .busy     (busy0)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk      (clk),
        .clear    (clear),
        .pi       (pi1),
        .load     (load1),
        .ready    (ready1),
        .so       (so1),
        .so_valid (so_valid1),
        .so_last  (so_last1),
        .busy     (busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // seq lists the expected serial bits in emission order, left to right.
    task automatic push_seq(input int d, input logic [3:0] seq, input bit first_contig);
        exp_t e;
        for (int i = 3; i >= 0; i--) begin
            e.b      = seq[i];
            e.last   = (i == 0);
            e.contig = (i == 3) ? first_contig : 1'b1;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic mon(input int d, input logic s, input logic v, input logic l, input logic bz);
        exp_t e;
        int   sz;
        sz = (d == 0) ? q0.size() : q1.size();
        n_cmp++;
        if (v === 1'b1) begin
            if (sz == 0) begin
                n_err++;
                $display("FAIL mon%0d_unexpected: got so=%b last=%b while no bit expected", d, s, l);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                if (s !== e.b || l !== e.last || bz !== 1'b1 || (e.contig && !prevv[d])) begin
                    n_err++;
                    $display("FAIL mon%0d_bit: got so=%b last=%b busy=%b prev_valid=%b required so=%b last=%b busy=1 contig=%b",
                             d, s, l, bz, prevv[d], e.b, e.last, e.contig);
                end
            end
        end else if (v !== 1'b0 || s !== 1'b0 || l !== 1'b0 || bz !== 1'b0) begin
            n_err++;
            $display("FAIL mon%0d_idle: got valid=%b so=%b last=%b busy=%b required all 0", d, v, s, l, bz);
        end
        prevv[d] = (v === 1'b1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, so0, so_valid0, so_last0, busy0);
            mon(1, so1, so_valid1, so_last1, busy1);
        end
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        prevv  = '0;
        mon_en = 1'b0;
        clear  = 1'b1;
        load0  = 1'b1;
        load1  = 1'b1;
        pi0    = 4'b1111;
        pi1    = 4'b1111;

        // Reset with load asserted: nothing may be accepted.
        tick();
        tick();
        clear = 1'b0;
        load0 = 1'b0;
        load1 = 1'b0;
        chk("rst_ready0", ready0, 1);
        chk("rst_valid0", so_valid0, 0);
        chk("rst_so0", so0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_ready1", ready1, 1);
        chk("rst_valid1", so_valid1, 0);
        mon_en = 1'b1;
        repeat (3) tick();

        // Single word, MSB first: 1001 -> 1,0,0,1.
        pi0   = 4'b1001;
        load0 = 1'b1;
        push_seq(0, 4'b1001, 1'b0);
        tick();
        load0 = 1'b0;
        chk("single_ready_mid", ready0, 0);
        repeat (3) tick();
        chk("single_ready_last", ready0, 1);
        chk("single_so_last", so_last0, 1);
        tick();
        chk("single_idle_valid", so_valid0, 0);
        chk("single_idle_ready", ready0, 1);
        chk("single_q_empty", q0.size(), 0);
        tick();

        // Back-to-back: 1010 then 1011 with load held.
        pi0   = 4'b1010;
        load0 = 1'b1;
        push_seq(0, 4'b1010, 1'b0);
        push_seq(0, 4'b1011, 1'b1);
        tick();
        pi0 = 4'b1011;
        tick();
        chk("b2b_ready_cnt1", ready0, 0);
        tick();
        tick();
        chk("b2b_ready_cnt3", ready0, 1);
        tick();
        load0 = 1'b0;
        chk("b2b_valid_word2", so_valid0, 1);
        repeat (3) tick();
        tick();
        chk("b2b_idle_valid", so_valid0, 0);
        chk("b2b_q_empty", q0.size(), 0);
        tick();

        // Load while busy is dropped: 0110 stays 0,1,1,0.
        pi0   = 4'b0110;
        load0 = 1'b1;
        push_seq(0, 4'b0110, 1'b0);
        tick();
        load0 = 1'b0;
        tick();
        pi0   = 4'b1111;
        load0 = 1'b1;
        chk("busy_ready_cnt1", ready0, 0);
        tick();
        load0 = 1'b0;
        tick();
        tick();
        chk("busy_idle_valid", so_valid0, 0);
        chk("busy_idle_ready", ready0, 1);
        chk("busy_q_empty", q0.size(), 0);
        tick();

        // Clear mid-frame: 1110 aborted at cnt=2, last 0 never emitted.
        pi0   = 4'b1110;
        load0 = 1'b1;
        q0.push_back('{b: 1'b1, last: 1'b0, contig: 1'b0});
        q0.push_back('{b: 1'b1, last: 1'b0, contig: 1'b1});
        q0.push_back('{b: 1'b1, last: 1'b0, contig: 1'b1});
        tick();
        load0 = 1'b0;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_valid", so_valid0, 0);
        chk("clr_so", so0, 0);
        chk("clr_ready", ready0, 1);
        chk("clr_busy", busy0, 0);
        repeat (4) tick();
        chk("clr_q_empty", q0.size(), 0);

        // LSB first: 1110 -> 0,1,1,1.
        pi1   = 4'b1110;
        load1 = 1'b1;
        push_seq(1, 4'b0111, 1'b0);
        tick();
        load1 = 1'b0;
        repeat (3) tick();
        chk("lsb_so_last", so_last1, 1);
        tick();
        chk("lsb_idle_valid", so_valid1, 0);
        chk("lsb_idle_ready", ready1, 1);
        chk("lsb_q_empty", q1.size(), 0);
        tick();

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
